// File: rtl/forth_pkg.sv
// Shared definitions for the Forth boot loader: loader states, image-format
// constants and the state-to-output decode.
package forth_pkg;

  localparam int LEN_BYTES = 2;
  localparam int CHK_WIDTH = 8;
  localparam int LEN_WIDTH = LEN_BYTES * 8;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    CHECK,
    RUN,
    ERROR
  } state_t;

  typedef struct packed {
    logic rx_ready;
    logic core_reset;
    logic busy;
    logic done;
    logic error;
  } flags_t;

  function automatic flags_t decode_flags(state_t s);
    flags_t f;
    f.rx_ready   = (s != RUN) && (s != ERROR);
    f.core_reset = (s != RUN);
    f.busy       = f.rx_ready;
    f.done       = (s == RUN);
    f.error      = (s == ERROR);
    return f;
  endfunction

endpackage

// File: rtl/forth_boot_loader_if.sv
// Byte-stream load port, status flags and core fetch port of the boot loader.
interface forth_boot_loader_if #(
  parameter int iaddr_width = 10
) ();

  logic                   load_req;
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic                   core_reset;
  logic [iaddr_width-1:0] core_iaddr;
  logic [15:0]            core_idata;
  logic                   busy;
  logic                   done;
  logic                   error;

  modport slave (
    input  load_req, rx_data, rx_valid, core_iaddr,
    output rx_ready, core_reset, core_idata, busy, done, error
  );

  modport master (
    output load_req, rx_data, rx_valid, core_iaddr,
    input  rx_ready, core_reset, core_idata, busy, done, error
  );

endinterface

// File: rtl/forth_imem.sv
// Instruction RAM: one write port for the loader, one registered read port
// for the core. The array itself has no reset so it maps onto block RAM.
module forth_imem #(
  parameter int iaddr_width = 10,
  parameter int instr_width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [iaddr_width-1:0] waddr,
  input  logic [instr_width-1:0] wdata,
  input  logic [iaddr_width-1:0] raddr,
  output logic [instr_width-1:0] rdata
);

  logic [instr_width-1:0] mem [2**iaddr_width];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset, which block RAMs support natively.
  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/forth_boot_loader.sv
// Boot loader: receives a length-prefixed, checksummed program image, writes
// it into instruction RAM and releases the core once the image checks good.
//
// state   | meaning
// --------+-----------------------------------------------
// LEN_LO  | waiting for low byte of word count
// LEN_HI  | waiting for high byte of word count
// DATA_LO | waiting for low byte of next word
// DATA_HI | waiting for high byte; word written on accept
// CHECK   | waiting for checksum byte
// RUN     | image good, core released and fetching
// ERROR   | image rejected (too long or bad checksum)
module forth_boot_loader
  import forth_pkg::*;
#(
  parameter int iaddr_width = 10,
  parameter int instr_width = 16
) (
  input logic                clk,
  input logic                reset,
  forth_boot_loader_if.slave bus
);

  state_t                 state;
  state_t                 state_nxt;
  flags_t                 flags;
  logic [iaddr_width:0]   ptr;
  logic [CHK_WIDTH-1:0]   sum;
  logic [CHK_WIDTH-1:0]   chk_sum;
  logic [7:0]             lo;
  logic [LEN_WIDTH-1:0]   len;
  logic [LEN_WIDTH-1:0]   len_new;
  logic                   xfer;
  logic                   last_word;
  logic                   too_long;
  logic                   we;

  assign xfer      = bus.rx_valid & flags.rx_ready;
  assign len_new   = {bus.rx_data, len[7:0]};
  assign too_long  = int'(len_new) > (1 << iaddr_width);
  assign last_word = LEN_WIDTH'(ptr) == (len - LEN_WIDTH'(1));
  assign chk_sum   = sum + bus.rx_data;
  assign we        = xfer & ~bus.load_req & (state == DATA_HI);

  always_comb begin
    state_nxt = state;
    if (bus.load_req) begin
      state_nxt = LEN_LO;
    end else if (xfer) begin
      case (state)
        LEN_LO:  state_nxt = LEN_HI;
        LEN_HI: begin
          if (too_long)             state_nxt = ERROR;
          else if (len_new == '0)   state_nxt = CHECK;
          else                      state_nxt = DATA_LO;
        end
        DATA_LO: state_nxt = DATA_HI;
        DATA_HI: state_nxt = last_word ? CHECK : DATA_LO;
        CHECK:   state_nxt = (chk_sum == '0) ? RUN : ERROR;
        default: state_nxt = state;
      endcase
    end
  end

  // Flags are registered from the next state so they switch on the same edge
  // as the state itself without a decode path after the flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LEN_LO;
      flags <= decode_flags(LEN_LO);
      ptr   <= '0;
      sum   <= '0;
      lo    <= '0;
      len   <= '0;
    end else begin
      state <= state_nxt;
      flags <= decode_flags(state_nxt);
      if (bus.load_req) begin
        ptr <= '0;
        sum <= '0;
        lo  <= '0;
      end else if (xfer) begin
        case (state)
          LEN_LO:  len[7:0]  <= bus.rx_data;
          LEN_HI:  len[15:8] <= bus.rx_data;
          DATA_LO: begin
            lo  <= bus.rx_data;
            sum <= chk_sum;
          end
          DATA_HI: begin
            sum <= chk_sum;
            ptr <= ptr + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_ready   = flags.rx_ready;
  assign bus.core_reset = flags.core_reset;
  assign bus.busy       = flags.busy;
  assign bus.done       = flags.done;
  assign bus.error      = flags.error;

  forth_imem #(
    .iaddr_width(iaddr_width),
    .instr_width(instr_width)
  ) u_imem (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .waddr(ptr[iaddr_width-1:0]),
    .wdata({bus.rx_data, lo}),
    .raddr(bus.core_iaddr),
    .rdata(bus.core_idata)
  );

endmodule

// File: tb/tb_forth_boot_loader.sv
// Directed bench for forth_boot_loader: image loads, checksum accept/reject,
// length limits, rx_valid gaps, load_req aborts and fetch latency.
module tb_forth_boot_loader;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   ready_drop = 0;
  logic [7:0] big_chk;

  forth_boot_loader_if #(.iaddr_width(10)) bus ();

  forth_boot_loader #(
    .iaddr_width(10),
    .instr_width(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    int n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      tick();
      if (bus.rx_ready !== 1'b1) ready_drop++;
    end
    send(b);
  endtask

  task automatic pulse_load();
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
  endtask

  task automatic fetch(input logic [9:0] a, input logic [15:0] exp, input string tag);
    bus.core_iaddr = a;
    tick();
    check(tag, 32'(bus.core_idata), 32'(exp));
  endtask

  function automatic logic [15:0] big_word(input int i);
    return 16'((i * 40503 + 17) & 16'hFFFF);
  endfunction

  initial begin
    bus.load_req   = 1'b0;
    bus.rx_data    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.core_iaddr = '0;
    reset          = 1'b1;
    tick();
    tick();
    check("rst_rx_ready",   32'(bus.rx_ready),   32'd1);
    check("rst_core_reset", 32'(bus.core_reset), 32'd1);
    check("rst_busy",       32'(bus.busy),       32'd1);
    check("rst_done",       32'(bus.done),       32'd0);
    check("rst_error",      32'(bus.error),      32'd0);
    check("rst_idata",      32'(bus.core_idata), 32'd0);
    reset = 1'b0;
    tick();

    // N=2, words 0x1234 and 0xE040; data byte sum 0x166 -> CHK 0x9A
    send(8'h02); send(8'h00);
    send(8'h34); send(8'h12); send(8'h40);
    check("a_busy_mid", 32'(bus.busy), 32'd1);
    send(8'hE0);
    check("a_pre_chk_done",  32'(bus.done),       32'd0);
    check("a_pre_chk_creset", 32'(bus.core_reset), 32'd1);
    send(8'h9A);
    check("a_done",       32'(bus.done),       32'd1);
    check("a_core_reset", 32'(bus.core_reset), 32'd0);
    check("a_rx_ready",   32'(bus.rx_ready),   32'd0);
    check("a_busy",       32'(bus.busy),       32'd0);
    fetch(10'd0, 16'h1234, "a_fetch0");
    fetch(10'd1, 16'hE040, "a_fetch1");

    pulse_load();
    check("run_reload_creset", 32'(bus.core_reset), 32'd1);
    check("run_reload_done",   32'(bus.done),       32'd0);
    check("run_reload_ready",  32'(bus.rx_ready),   32'd1);

    // Same image, CHK off by one
    send(8'h02); send(8'h00);
    send(8'h34); send(8'h12); send(8'h40); send(8'hE0);
    send(8'h9B);
    check("bad_error",    32'(bus.error),      32'd1);
    check("bad_creset",   32'(bus.core_reset), 32'd1);
    check("bad_rx_ready", 32'(bus.rx_ready),   32'd0);
    check("bad_done",     32'(bus.done),       32'd0);

    pulse_load();
    check("err_reload_error", 32'(bus.error), 32'd0);
    send(8'h00); send(8'h00);
    check("n0_not_done", 32'(bus.done), 32'd0);
    send(8'h00);
    check("n0_done", 32'(bus.done), 32'd1);

    pulse_load();
    send(8'h01);
    check("n401_lenlo_error", 32'(bus.error), 32'd0);
    send(8'h04);
    check("n401_error", 32'(bus.error),    32'd1);
    check("n401_ready", 32'(bus.rx_ready), 32'd0);

    // N=0x400 fills the whole RAM
    pulse_load();
    big_chk = 8'h00;
    send(8'h00); send(8'h04);
    check("n400_accepted", 32'(bus.error), 32'd0);
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] w;
      w = big_word(i);
      big_chk = big_chk - w[7:0] - w[15:8];
      send(w[7:0]);
      send(w[15:8]);
    end
    send(big_chk);
    check("n400_done", 32'(bus.done), 32'd1);
    fetch(10'h3FF, big_word(1023), "n400_last");
    fetch(10'h000, big_word(0),    "n400_first");
    fetch(10'h200, big_word(512),  "n400_mid");

    // 4-word image with random rx_valid gaps; data byte sum 0x3F4 -> CHK 0x0C
    pulse_load();
    send_gap(8'h04); send_gap(8'h00);
    send_gap(8'hB2); send_gap(8'hA1);
    send_gap(8'hD4); send_gap(8'hC3);
    send_gap(8'h06); send_gap(8'h05);
    send_gap(8'h80); send_gap(8'h7F);
    send_gap(8'h0C);
    check("gap_rx_ready", 32'(ready_drop), 32'd0);
    check("gap_done",     32'(bus.done),   32'd1);
    fetch(10'd0, 16'hA1B2, "gap_w0");
    fetch(10'd1, 16'hC3D4, "gap_w1");
    fetch(10'd2, 16'h0506, "gap_w2");
    fetch(10'd3, 16'h7F80, "gap_w3");

    // Abort mid-DATA_HI: the coincident byte must not complete word 0
    pulse_load();
    send(8'h02); send(8'h00); send(8'h11);
    bus.load_req = 1'b1;
    send(8'h22);
    bus.load_req = 1'b0;
    check("abort_creset", 32'(bus.core_reset), 32'd1);
    check("abort_ready",  32'(bus.rx_ready),   32'd1);
    fetch(10'd0, 16'hA1B2, "abort_not_written");

    // 1-word image 0xBEEF; byte sum 0x1AD -> CHK 0x53
    send(8'h01); send(8'h00); send(8'hEF); send(8'hBE);
    send(8'h53);
    check("beef_done", 32'(bus.done), 32'd1);
    fetch(10'd0,   16'hBEEF,        "beef_w0");
    fetch(10'd1,   16'hC3D4,        "beef_keep1");
    fetch(10'd3,   16'h7F80,        "beef_keep3");
    fetch(10'h3FF, big_word(1023),  "beef_keep3ff");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
